// File: rtl/muldiv_hilo.sv
// muldiv_hilo
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU take WIDTH RUN cycles (one bit per cycle) plus one
// FIX cycle that applies result signs and writes Hi/Lo.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset; aborts any operation
//   i_start      begin operation i_op (only looked at in IDLE)
//   i_op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_operandA   rs: multiplicand/dividend, also MTHI/MTLO data
//   i_operandB   rt: multiplier/divisor
//   i_hiWrite    MTHI, honoured only in IDLE
//   i_loWrite    MTLO, honoured only in IDLE
//   o_busy       high while an operation is in flight
//   o_done       one-cycle pulse when a new result lands in Hi/Lo
//   o_divByZero  qualifies o_done for a DIV/DIVU with a zero divisor
//   o_hi, o_lo   HI/LO registers
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operandA,
  input  logic [WIDTH-1:0] i_operandB,
  input  logic             i_hiWrite,
  input  logic             i_loWrite,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_divByZero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_isDiv;
  logic               r_divZero;
  logic               r_negLo;
  logic               r_negHi;
  logic [WIDTH-1:0]   r_origA;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_divByZero;

  logic               w_signA;
  logic               w_signB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Operand signs only matter for the signed ops (op bit 0 clear); the
  // unsigned ops pass raw values straight through as magnitudes.
  // The most negative value maps to itself, which is the correct
  // unsigned magnitude, so no special case is needed.
  always_comb begin
    w_signA = i_operandA[WIDTH-1] & ~i_op[0];
    w_signB = i_operandB[WIDTH-1] & ~i_op[0];
    w_magA  = w_signA ? -i_operandA : i_operandA;
    w_magB  = w_signB ? -i_operandB : i_operandB;
  end

  // One iteration of each algorithm. The accumulator holds {upper, lower}:
  // multiply keeps the partial product above the not-yet-consumed
  // multiplier bits; divide keeps the partial remainder above the
  // dividend bits that are turning into quotient bits. A set top bit in
  // the trial subtraction means a borrow, i.e. the restore case.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opnd};
  end

  // Sign fix-up applied in FIX: the full product is negated as one
  // 2*WIDTH value, while quotient and remainder carry separate signs so
  // the quotient truncates toward zero and the remainder follows the
  // dividend.
  always_comb begin
    w_product = r_negLo ? -r_acc : r_acc;
    w_quot    = r_negLo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem     = r_negHi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Main sequencer. IDLE accepts Start and MTHI/MTLO (together if both
  // arrive in the same cycle), RUN iterates WIDTH times on a down-counter,
  // FIX writes Hi/Lo and pulses Done. Anything arriving while busy is
  // simply dropped; the controller is expected to stall on Busy.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_isDiv     <= 1'b0;
      r_divZero   <= 1'b0;
      r_negLo     <= 1'b0;
      r_negHi     <= 1'b0;
      r_origA     <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_divByZero <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_hiWrite) r_hi <= i_operandA;
          if (i_loWrite) r_lo <= i_operandA;
          if (i_start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_count   <= CW'(WIDTH - 1);
            r_isDiv   <= i_op[1];
            r_divZero <= i_op[1] & (i_operandB == '0);
            r_negLo   <= w_signA ^ w_signB;
            r_negHi   <= i_op[1] & w_signA;
            r_origA   <= i_operandA;
            // Multiply consumes the multiplier from the low half; divide
            // shifts the dividend out of the low half.
            if (i_op[1]) begin
              r_opnd <= w_magB;
              r_acc  <= {{WIDTH{1'b0}}, w_magA};
            end else begin
              r_opnd <= w_magA;
              r_acc  <= {{WIDTH{1'b0}}, w_magB};
            end
          end
        end
        RUN: begin
          if (r_isDiv) begin
            if (!w_trial[WIDTH])
              r_acc <= {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
              r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
          end else begin
            if (r_acc[0])
              r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            else
              r_acc <= {1'b0, r_acc[2*WIDTH-1:1]};
          end
          if (r_count == '0) r_state <= FIX;
          else               r_count <= r_count - 1'b1;
        end
        FIX: begin
          if (!r_isDiv) begin
            {r_hi, r_lo} <= w_product;
          end else if (r_divZero) begin
            r_hi <= r_origA;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_done      <= 1'b1;
          r_divByZero <= r_isDiv & r_divZero;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_divByZero = r_divByZero;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo
// Drives muldiv_hilo through directed and random multiply/divide
// operations, MTHI/MTLO writes, dropped requests while busy and a
// mid-operation reset, comparing against a plain-arithmetic model.
module tb_muldiv_hilo;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  operandA;
  logic [W-1:0]  operandB;
  logic          hiWrite;
  logic          loWrite;
  logic          busy;
  logic          done;
  logic          divByZero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int fails  = 0;

  muldiv_hilo #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_op        (op),
    .i_operandA  (operandA),
    .i_operandB  (operandB),
    .i_hiWrite   (hiWrite),
    .i_loWrite   (loWrite),
    .o_busy      (busy),
    .o_done      (done),
    .o_divByZero (divByZero),
    .o_hi        (hi),
    .o_lo        (lo)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference result {Hi, Lo} straight from the arithmetic definition of
  // each instruction, using 64-bit integers so DIV overflow is well defined.
  function automatic logic [63:0] refModel(input logic [1:0] opIn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint m;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (opIn)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          m = sa % sb;
          r = {m[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) r = {a, 32'hFFFFFFFF};
        else        r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // Issue one operation with Start in an IDLE cycle and follow it to
  // Done, reporting latency in edges after the Start edge, number of
  // Busy cycles seen, Busy during the Done cycle and the result.
  // lat stays -1 if Done never arrives within the budget.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, output int lat,
                               output int busyCnt, output logic doneBusy,
                               output logic [31:0] hiOut, output logic [31:0] loOut,
                               output logic dbzOut);
    @(negedge clk);
    op = opIn; operandA = a; operandB = b; start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    busyCnt  = busy ? 1 : 0;
    lat      = -1;
    doneBusy = 1'b1;
    hiOut    = '0;
    loOut    = '0;
    dbzOut   = 1'b0;
    for (int c = 1; c <= W + 10 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; doneBusy = busy; hiOut = hi; loOut = lo; dbzOut = divByZero;
      end else if (busy) busyCnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
    hiWrite = 1'b0; loWrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, divByZero} !== 3'b000) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, divByZero});
    end
    checks++;
    if (hi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++;
    if (lo !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b0;
  endtask

  // Directed and signed/unsigned multiply, including full timing checks.
  task automatic test_mult();
    logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b00};
    logic [31:0] as  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    logic [31:0] bs  [3] = '{32'hFFFFFFFF, 32'h00000007, 32'h80000000};
    logic [31:0] eh  [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};
    logic [31:0] el  [3] = '{32'h00000001, 32'hFFFFFFEB, 32'h00000000};
    int lat, bc;
    logic db, dz;
    logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], as[i], bs[i], lat, bc, db, h, l, dz);
      checks++;
      if (lat !== W + 1) begin fails++; $display("[TB] FAIL mult_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      checks++;
      if (bc !== W + 1 || db !== 1'b0) begin
        fails++; $display("[TB] FAIL mult_busy[%0d]: got %0d cycles (busy at done %b) expected %0d (0)", i, bc, db, W + 1);
      end
      checks++;
      if ({h, l} !== {eh[i], el[i]}) begin
        fails++; $display("[TB] FAIL mult_result[%0d]: got %h_%h expected %h_%h", i, h, l, eh[i], el[i]);
      end
      checks++;
      if (dz !== 1'b0) begin fails++; $display("[TB] FAIL mult_dbz[%0d]: got %b expected 0", i, dz); end
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || divByZero !== 1'b0) begin
      fails++; $display("[TB] FAIL done_pulse_width: got done=%b dbz=%b expected 0 0", done, divByZero);
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [3] = '{2'b10, 2'b11, 2'b10};
    logic [31:0] as  [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] bs  [3] = '{32'h00000002, 32'h00000002, 32'hFFFFFFFF};
    logic [31:0] eh  [3] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    logic [31:0] el  [3] = '{32'hFFFFFFFD, 32'h7FFFFFFC, 32'h80000000};
    int lat, bc;
    logic db, dz;
    logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], as[i], bs[i], lat, bc, db, h, l, dz);
      checks++;
      if (lat !== W + 1) begin fails++; $display("[TB] FAIL div_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      checks++;
      if ({h, l} !== {eh[i], el[i]}) begin
        fails++; $display("[TB] FAIL div_result[%0d]: got %h_%h expected %h_%h", i, h, l, eh[i], el[i]);
      end
      checks++;
      if (dz !== 1'b0) begin fails++; $display("[TB] FAIL div_dbz[%0d]: got %b expected 0", i, dz); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [1:0]  ops [3] = '{2'b11, 2'b11, 2'b10};
    logic [31:0] as  [3] = '{32'h00000005, 32'h00000005, 32'hFFFFFFF8};
    logic [31:0] bs  [3] = '{32'h00000000, 32'h00000001, 32'h00000000};
    logic [31:0] eh  [3] = '{32'h00000005, 32'h00000000, 32'hFFFFFFF8};
    logic [31:0] el  [3] = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF};
    logic        ez  [3] = '{1'b1, 1'b0, 1'b1};
    int lat, bc;
    logic db, dz;
    logic [31:0] h, l;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], as[i], bs[i], lat, bc, db, h, l, dz);
      checks++;
      if (lat !== W + 1) begin fails++; $display("[TB] FAIL dbz_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      checks++;
      if ({h, l} !== {eh[i], el[i]}) begin
        fails++; $display("[TB] FAIL dbz_result[%0d]: got %h_%h expected %h_%h", i, h, l, eh[i], el[i]);
      end
      checks++;
      if (dz !== ez[i]) begin fails++; $display("[TB] FAIL dbz_flag[%0d]: got %b expected %b", i, dz, ez[i]); end
    end
  endtask

  // Each operation starts in the Done cycle of the previous one, so this
  // also exercises back-to-back acceptance every W+1 cycles.
  task automatic test_back_to_back();
    int lat, bc;
    logic db, dz;
    logic [31:0] h, l, a, b;
    logic [1:0] o;
    logic [63:0] exp;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      exp = refModel(o, a, b);
      applyStimulus(o, a, b, lat, bc, db, h, l, dz);
      checks++;
      if (lat !== W + 1) begin fails++; $display("[TB] FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, W + 1); end
      checks++;
      if ({h, l} !== exp) begin
        fails++; $display("[TB] FAIL b2b_result[%0d] op=%b a=%h b=%h: got %h_%h expected %h", i, o, a, b, h, l, exp);
      end
      checks++;
      if (dz !== (o[1] && b == 0)) begin
        fails++; $display("[TB] FAIL b2b_dbz[%0d]: got %b expected %b", i, dz, (o[1] && b == 0));
      end
    end
  endtask

  // MTHI/MTLO in IDLE, then requests that arrive mid-RUN must be dropped.
  task automatic test_busy_drop();
    int doneCnt, doneAt;
    logic [31:0] h, l;
    @(negedge clk);
    hiWrite = 1'b1; operandA = 32'h1234;
    @(posedge clk); #1;
    hiWrite = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin fails++; $display("[TB] FAIL mthi: got %h expected 00001234", hi); end
    @(negedge clk);
    hiWrite = 1'b1; loWrite = 1'b1; operandA = 32'hABCD;
    @(posedge clk); #1;
    hiWrite = 1'b0; loWrite = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hABCD, 32'hABCD}) begin
      fails++; $display("[TB] FAIL mthi_mtlo: got %h_%h expected 0000abcd_0000abcd", hi, lo);
    end
    @(negedge clk);
    start = 1'b1; op = 2'b01; operandA = 32'd2; operandB = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    hiWrite = 1'b1; loWrite = 1'b1; start = 1'b1; op = 2'b00;
    operandA = 32'hDEAD; operandB = 32'd7;
    @(posedge clk); #1;
    hiWrite = 1'b0; loWrite = 1'b0; start = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hABCD, 32'hABCD}) begin
      fails++; $display("[TB] FAIL busy_write_dropped: got %h_%h expected 0000abcd_0000abcd", hi, lo);
    end
    doneCnt = 0; doneAt = -1; h = '0; l = '0;
    for (int c = 7; c <= 2 * W + 10; c++) begin
      @(posedge clk); #1;
      if (done) begin doneCnt++; doneAt = c; h = hi; l = lo; end
    end
    checks++;
    if (doneCnt !== 1 || doneAt !== W + 1) begin
      fails++; $display("[TB] FAIL busy_single_done: got %0d dones (last at %0d) expected 1 at %0d", doneCnt, doneAt, W + 1);
    end
    checks++;
    if ({h, l} !== {32'h0, 32'h6}) begin
      fails++; $display("[TB] FAIL busy_result: got %h_%h expected 00000000_00000006", h, l);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bc, doneCnt;
    logic db, dz;
    logic [31:0] h, l;
    @(negedge clk);
    start = 1'b1; op = 2'b10; operandA = 32'd100; operandB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy, done, hi, lo} !== {2'b00, 64'h0}) begin
      fails++; $display("[TB] FAIL abort_state: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
    end
    doneCnt = 0;
    for (int c = 0; c < W + 5; c++) begin
      @(posedge clk); #1;
      if (done || busy) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", doneCnt); end
    applyStimulus(2'b01, 32'd4, 32'd5, lat, bc, db, h, l, dz);
    checks++;
    if (lat !== W + 1) begin fails++; $display("[TB] FAIL abort_restart_latency: got %0d expected %0d", lat, W + 1); end
    checks++;
    if ({h, l} !== {32'h0, 32'd20}) begin
      fails++; $display("[TB] FAIL abort_restart_result: got %h_%h expected 00000000_00000014", h, l);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_busy_drop();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Iterative multiply/divide unit with the architectural HI/LO register pair. It sits directly downstream of the 32×32 register file: ReadData1 (rs) and ReadData2 (rt) feed OperandA and OperandB. The unit executes MULT/MULTU/DIV/DIVU over multiple cycles, holds the 64-bit result in HI/LO, and serves MFHI/MFLO reads and MTHI/MTLO writes. Busy stalls the datapath controller while an operation is in flight.

## Interface
- WIDTH, 32, operand width; also the iteration count of the RUN state.

- Clock  in  1  single clock; all state changes on the rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  begin operation Op; sampled only in IDLE
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- OperandA  in  WIDTH  rs value: multiplicand/dividend; also the MTHI/MTLO data
- OperandB  in  WIDTH  rt value: multiplier/divisor
- HiWrite  in  1  MTHI: Hi <= OperandA
- LoWrite  in  1  MTLO: Lo <= OperandA
- Busy  out  1  high while state != IDLE
- Done  out  1  one-cycle pulse when a new result is in Hi/Lo
- DivByZero  out  1  valid with Done; high if the completed DIV/DIVU had OperandB == 0
- Hi  out  WIDTH  HI register (product upper half / remainder)
- Lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- FSM states:
  - IDLE -> RUN on Start.
  - RUN -> FIX after WIDTH cycles; a down-counter counts WIDTH-1..0.
  - FIX -> IDLE unconditionally.
- Start accept: latch the op, signedness, operand magnitudes, and result sign flags. Signed ops use |x|; unsigned ops use raw values.
- Multiply:
  - Unsigned shift-add, one multiplier bit per RUN cycle, into a 2·WIDTH accumulator.
  - In FIX, negate the 2·WIDTH product if the op is signed and the operand signs differ.
  - {Hi,Lo} = product.
- Divide:
  - Restoring division, one quotient bit per RUN cycle.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Lo = quotient, Hi = remainder.
- DIV overflow: 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0. This is the natural result of the magnitude path and needs no special case.
- Divide by zero:
  - The operation runs the full latency.
  - Lo = all ones; Hi = OperandA as latched (original signed value).
  - DivByZero = 1 with Done.
- Hi and Lo change only on FIX exit, HiWrite/LoWrite, or Reset.
- HiWrite/LoWrite:
  - Honoured only in IDLE; dropped while Busy. The controller must stall MTHI/MTLO/MFHI/MFLO on Busy.
  - HiWrite and LoWrite may be asserted together.
- Start with HiWrite/LoWrite in the same IDLE cycle: both take effect. The later result overwrites Hi/Lo.
- Start while Busy: ignored; there is no queueing.
- Reset:
  - All outputs are 0 (Hi, Lo, Busy, Done, DivByZero); state = IDLE.
  - Reset mid-operation aborts the operation. No Done, and Hi/Lo are cleared.

## Timing
- Start sampled high at edge E0 (IDLE): Busy = 1 from after E0 through edge E0+WIDTH+1, i.e. WIDTH cycles in RUN plus 1 in FIX.
- Hi/Lo are updated at edge E0+WIDTH+1.
- Done (and DivByZero, if applicable) is high for exactly one cycle after that edge. In that cycle Busy = 0.
- A new Start is accepted in the Done cycle, giving back-to-back operations every WIDTH+1 cycles.
- HiWrite/LoWrite: Hi/Lo are visible the cycle after the write edge.
- Hi/Lo are registered outputs with no combinational path from inputs.
- Done and DivByZero are 0 in every cycle other than the Done cycle.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001; Done exactly 33 edges after the Start edge; Busy high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> Hi = 0x40000000, Lo = 0.
- DIV −7 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> Lo = 0x7FFFFFFC, Hi = 1. DIV 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0.
- DIVU 5 / 0 -> Lo = 0xFFFFFFFF, Hi = 5, DivByZero = 1 with Done. A following DIVU 5 / 1 -> DivByZero = 0, Lo = 5, Hi = 0.
- HiWrite with OperandA = 0x1234 in IDLE -> Hi = 0x1234 the next cycle. Then start MULTU 2 × 3 and pulse HiWrite and Start mid-RUN -> both are dropped; final Hi = 0, Lo = 6, a single Done.
- Reset asserted in RUN cycle 10 of a DIV -> next cycle Busy = 0, Hi = Lo = 0, no Done. A fresh MULTU 4 × 5 -> Lo = 20 at normal latency.
